// File: rtl/pingpong_frame_buffer.sv
// pingpong_frame_buffer
//   Double-buffered frame store between the telemetry frame former (writer)
//   and the DAC/serial output distributor (reader). The writer always fills
//   the bank not being read; a commit marks that bank as a complete frame and
//   the next frame_sync swaps it into the read side. If frame_sync arrives
//   with nothing committed the reader either repeats the last frame or emits
//   FILL_WORD, depending on REPEAT_ON_STARVE.
//
// Ports
//   clk, reset       : system clock, synchronous active-high reset
//   wr_en/addr/data  : word write into the current write bank
//   wr_commit        : write bank now holds a complete frame
//   wr_ready         : no frame pending; writes and commits are accepted
//   frame_sync       : output frame start; swaps banks when a frame is pending
//   rd_strobe        : request one output word
//   rd_data/rd_valid : registered word, valid pulse one clock after rd_strobe
//   rd_bank          : bank currently being read
//   underrun/overrun : single-cycle event pulses
//   underrun_cnt/overrun_cnt : saturating event counters
module pingpong_frame_buffer #(
  parameter int              DATA_W           = 8,
  parameter int              ADDR_W           = 7,
  parameter int              DEPTH            = 128,
  parameter bit              REPEAT_ON_STARVE = 1'b1,
  parameter logic [DATA_W-1:0] FILL_WORD      = '0,
  parameter int              CNT_W            = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_commit,
  output logic              wr_ready,
  input  logic              frame_sync,
  input  logic              rd_strobe,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_bank,
  output logic              underrun,
  output logic              overrun,
  output logic [CNT_W-1:0]  underrun_cnt,
  output logic [CNT_W-1:0]  overrun_cnt
);

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

  // Full address-space rows keep indexing width-exact; only the first DEPTH
  // words of each bank are ever written.
  logic [DATA_W-1:0] mem [2][2**ADDR_W];

  logic              pending;
  logic [1:0]        bank_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic              starved;

  logic              wr_ok, commit_ok, swap, ovr_evt, und_evt;
  logic              eff_bank, eff_starved;
  logic [ADDR_W-1:0] eff_addr, next_addr;

  assign wr_ready = ~pending;

  // The read in the same cycle as frame_sync must see the post-sync bank,
  // starve state and address 0, so all read-side selection goes through the
  // eff_* view of the state.
  always_comb begin
    wr_ok       = wr_en & ~pending & ({1'b0, wr_addr} < DEPTH_X);
    commit_ok   = wr_commit & ~pending;
    ovr_evt     = pending & (wr_en | wr_commit);
    swap        = frame_sync & (pending | wr_commit);
    und_evt     = frame_sync & ~swap;
    eff_bank    = swap ? ~rd_bank : rd_bank;
    eff_addr    = frame_sync ? '0 : rd_addr;
    eff_starved = starved;
    if (swap)
      eff_starved = 1'b0;
    else if (frame_sync)
      eff_starved = (REPEAT_ON_STARVE == 1'b0) | ~bank_valid[rd_bank];
    next_addr   = (eff_addr == LAST) ? '0 : eff_addr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[~rd_bank][wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_bank      <= 1'b0;
      pending      <= 1'b0;
      bank_valid   <= 2'b00;
      rd_addr      <= '0;
      starved      <= 1'b1;
      rd_data      <= FILL_WORD;
      rd_valid     <= 1'b0;
      underrun     <= 1'b0;
      overrun      <= 1'b0;
      underrun_cnt <= '0;
      overrun_cnt  <= '0;
    end else begin
      underrun <= und_evt;
      overrun  <= ovr_evt;
      rd_valid <= rd_strobe;

      if (commit_ok) bank_valid[~rd_bank] <= 1'b1;

      if (swap)           pending <= 1'b0;
      else if (commit_ok) pending <= 1'b1;

      rd_bank <= eff_bank;
      starved <= eff_starved;
      rd_addr <= rd_strobe ? next_addr : eff_addr;

      if (rd_strobe)
        rd_data <= eff_starved ? FILL_WORD : mem[eff_bank][eff_addr];

      if (und_evt && underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
      if (ovr_evt && overrun_cnt  != '1) overrun_cnt  <= overrun_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Bench for pingpong_frame_buffer: two instances (fill-on-starve and
// repeat-on-starve) share one stimulus stream; a frame-level reference model
// predicts every output after each clock.
module tb_pingpong_frame_buffer;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEP = 4;
  localparam int CW = 4;
  localparam logic [DW-1:0] FILL = 8'hE5;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset, wr_en, wr_commit, frame_sync, rd_strobe;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          wr_ready [2];
  logic [DW-1:0] rd_data  [2];
  logic          rd_valid [2];
  logic          rd_bank  [2];
  logic          underrun [2];
  logic          overrun  [2];
  logic [CW-1:0] underrun_cnt [2];
  logic [CW-1:0] overrun_cnt  [2];

  always #5 clk = ~clk;

  // instance 0: fill on starve, instance 1: repeat last frame
  for (genvar g = 0; g < 2; g++) begin : g_dut
    pingpong_frame_buffer #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP),
      .REPEAT_ON_STARVE(g == 1), .FILL_WORD(FILL), .CNT_W(CW)
    ) dut (
      .clk(clk), .reset(reset),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_commit(wr_commit), .wr_ready(wr_ready[g]),
      .frame_sync(frame_sync), .rd_strobe(rd_strobe),
      .rd_data(rd_data[g]), .rd_valid(rd_valid[g]), .rd_bank(rd_bank[g]),
      .underrun(underrun[g]), .overrun(overrun[g]),
      .underrun_cnt(underrun_cnt[g]), .overrun_cnt(overrun_cnt[g])
    );
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the reader's bank, whether a finished frame is waiting,
  // which banks ever held a committed frame, word position, and whether the
  // reader is currently starved of a usable frame.
  int          m_bank, m_pos, m_ucnt, m_ocnt;
  bit          m_waiting, m_starved, m_valid_out, m_und, m_ovr;
  bit          m_ever [2];
  logic [DW-1:0] m_word;
  logic [DW-1:0] m_mem [2][DEP];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      bit starve_now;
      starve_now = m_starved;
      check($sformatf("rd_data[%0d]", i), 32'(rd_data[i]), 32'(m_word_of(i)));
      check($sformatf("rd_valid[%0d]", i), 32'(rd_valid[i]), 32'(m_valid_out));
      check($sformatf("rd_bank[%0d]", i), 32'(rd_bank[i]), 32'(m_bank));
      check($sformatf("underrun[%0d]", i), 32'(underrun[i]), 32'(m_und));
      check($sformatf("overrun[%0d]", i), 32'(overrun[i]), 32'(m_ovr));
      check($sformatf("underrun_cnt[%0d]", i), 32'(underrun_cnt[i]), 32'(m_ucnt));
      check($sformatf("overrun_cnt[%0d]", i), 32'(overrun_cnt[i]), 32'(m_ocnt));
      check($sformatf("wr_ready[%0d]", i), 32'(wr_ready[i]), 32'(!m_waiting));
      if (starve_now) begin end
    end
  endtask

  // Per-instance output word and starve flag: the two instances differ only
  // in what an unfed frame_sync does, so those are kept per instance.
  logic [DW-1:0] w_out [2];
  bit            w_starved [2];
  function automatic logic [DW-1:0] m_word_of(input int i);
    return w_out[i];
  endfunction

  task automatic model_reset();
    m_bank = 0; m_pos = 0; m_ucnt = 0; m_ocnt = 0;
    m_waiting = 0; m_starved = 1; m_valid_out = 0; m_und = 0; m_ovr = 0;
    m_ever[0] = 0; m_ever[1] = 0;
    for (int i = 0; i < 2; i++) begin w_out[i] = FILL; w_starved[i] = 1; end
  endtask

  task automatic model_step(input bit we, input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd, input bit wc,
                            input bit fs, input bit rs);
    int  wbank, rbank, pos;
    bit  frame_ready, accepted_commit;
    wbank = 1 - m_bank;
    accepted_commit = wc && !m_waiting;
    frame_ready = m_waiting || wc;
    m_ovr = m_waiting && (we || wc);
    if (m_ovr && m_ocnt < SAT) m_ocnt++;
    m_und = fs && !frame_ready;
    if (m_und && m_ucnt < SAT) m_ucnt++;
    rbank = (fs && frame_ready) ? wbank : m_bank;
    pos   = fs ? 0 : m_pos;
    for (int i = 0; i < 2; i++) begin
      if (fs && frame_ready)  w_starved[i] = 0;
      else if (fs)            w_starved[i] = (i == 0) || !m_ever[m_bank];
      if (rs) w_out[i] = w_starved[i] ? FILL : m_mem[rbank][pos];
    end
    m_valid_out = rs;
    m_pos = rs ? (pos + 1) % DEP : pos;
    // memory update after the read: a same-cycle write cannot be seen
    if (we && !m_waiting && int'(wa) < DEP) m_mem[wbank][wa] = wd;
    if (accepted_commit) m_ever[wbank] = 1;
    if (fs && frame_ready) m_waiting = 0;
    else if (accepted_commit) m_waiting = 1;
    m_bank = rbank;
  endtask

  task automatic step(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit wc, input bit fs, input bit rs);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_commit = wc;
    frame_sync = fs; rd_strobe = rs;
    @(posedge clk);
    model_step(we, wa, wd, wc, fs, rs);
    #1;
    check_all();
  endtask

  task automatic do_reset(input bit rs);
    reset = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0; wr_commit = 0;
    frame_sync = 1'b1; rd_strobe = rs;
    @(posedge clk);
    model_reset();
    #1;
    check_all();
    reset = 1'b0; frame_sync = 0; rd_strobe = 0;
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, 0); endtask
  task automatic strobe4();
    for (int k = 0; k < DEP; k++) begin step(0, 0, 0, 0, 0, 1); idle(); end
  endtask

  initial begin
    reset = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0;
    wr_commit = 0; frame_sync = 0; rd_strobe = 0;
    model_reset();
    do_reset(0);
    do_reset(0);

    // no frame ever committed: fill words on both instances
    strobe4();
    check("dir_fill_r0", 32'(rd_data[0]), 32'(FILL));
    check("dir_fill_r1", 32'(rd_data[1]), 32'(FILL));

    // first frame into bank 1; out-of-range address ignored
    for (int k = 0; k < DEP; k++) step(1, AW'(k), DW'(8'h10 + k), 0, 0, 0);
    step(1, 3'd5, 8'h99, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    check("dir_bank1", 32'(rd_bank[0]), 32'd1);
    strobe4();
    check("dir_last13", 32'(rd_data[1]), 32'h13);

    // unfed frame_sync: repeat vs fill
    step(0, 0, 0, 0, 1, 0);
    check("dir_underrun", 32'(underrun[1]), 32'd1);
    strobe4();
    check("dir_repeat13", 32'(rd_data[1]), 32'h13);
    check("dir_fill13", 32'(rd_data[0]), 32'(FILL));

    // commit frame A into bank 0, then a late write is an overrun
    for (int k = 0; k < DEP; k++) step(1, AW'(k), DW'(8'h20 + k), 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 3'd0, 8'hAA, 0, 0, 0);
    check("dir_overrun", 32'(overrun[0]), 32'd1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    check("dir_not_aa", 32'(rd_data[0]), 32'h20);
    idle();

    // commit, sync and strobe together: word 0 of the new frame next cycle
    for (int k = 0; k < DEP; k++) step(1, AW'(k), DW'(8'h30 + k), 0, 0, 0);
    step(0, 0, 0, 1, 1, 1);
    check("dir_same_cycle", 32'(rd_data[1]), 32'h30);
    check("dir_no_underrun", 32'(underrun[0]), 32'd0);
    idle();

    // randomized traffic
    for (int n = 0; n < 400; n++)
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 5)), DW'($urandom),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 4) < 2));

    // counter saturation
    for (int n = 0; n < SAT + 4; n++) begin
      step(0, 0, 0, 0, 1, 1'($urandom_range(0, 1)));
      idle();
    end
    check("dir_ucnt_sat", 32'(underrun_cnt[0]), 32'(SAT));

    // reset mid-frame, then the next sync must underrun
    step(0, 0, 0, 0, 0, 1);
    step(1, 3'd1, 8'h55, 1, 0, 1);
    do_reset(1);
    step(0, 0, 0, 0, 1, 0);
    check("dir_post_reset_und", 32'(underrun_cnt[1]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
